// File: rtl/uart_pkg.sv
// Shared UART definitions: line-rate encoding, receiver states, frame constants
// and the oversample divisor helper used by both receiver and transmitter.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        BAUD_9600   = 2'b00,
        BAUD_19200  = 2'b01,
        BAUD_57600  = 2'b10,
        BAUD_115200 = 2'b11
    } baudrate_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int unsigned baud_divisor(input int unsigned clock_freq_hz,
                                                 input baudrate_t   baud);
        int unsigned rate;
        case (baud)
            BAUD_9600:   rate = 9600;
            BAUD_19200:  rate = 19200;
            BAUD_57600:  rate = 57600;
            default:     rate = 115200;
        endcase
        return (clock_freq_hz + (OVERSAMPLE * rate) / 2) / (OVERSAMPLE * rate);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count, registered
// empty flag and registered level-threshold flag (threshold 0 acts as 1).
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH):0]   thresh_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     thresh_reached_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    thresh_eff;
    logic             empty_q, reached_q;
    logic             do_wr, do_rd;

    // A write into a full FIFO is still accepted when a pop frees a slot in the same cycle.
    always_comb begin
        do_rd      = rd_en_i && !empty_q;
        do_wr      = wr_en_i && ((count_q != CW'(DEPTH)) || do_rd);
        thresh_eff = (thresh_i == '0) ? CW'(1) : thresh_i;
        count_d    = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            reached_q <= 1'b0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q   <= count_d;
            empty_q   <= (count_d == '0);
            reached_q <= (count_d >= thresh_eff);
        end
    end

    always_ff @(posedge clock_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o        = empty_q ? '0 : mem_q[rd_ptr_q];
    assign count_o          = count_q;
    assign empty_o          = empty_q;
    assign thresh_reached_o = reached_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: line synchronizer, 16x oversample tick, frame FSM and
// shift register feeding a FWFT receive buffer with error pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ_HZ = 50_000_000,
    parameter int unsigned BUFFER_DEPTH  = 16
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          uart_rx_i,
    input  logic [1:0]                    baudrate_select_i,
    input  logic [$clog2(BUFFER_DEPTH):0] data_buffer_ready_tresh_i,
    input  logic                          data_read_i,
    output logic [7:0]                    data_o,
    output logic                          data_buffer_empty_o,
    output logic                          data_buffer_ready_o,
    output logic                          frame_error_o,
    output logic                          overrun_error_o
);

    localparam int unsigned DIV_9600   = baud_divisor(CLOCK_FREQ_HZ, BAUD_9600);
    localparam int unsigned DIV_19200  = baud_divisor(CLOCK_FREQ_HZ, BAUD_19200);
    localparam int unsigned DIV_57600  = baud_divisor(CLOCK_FREQ_HZ, BAUD_57600);
    localparam int unsigned DIV_115200 = baud_divisor(CLOCK_FREQ_HZ, BAUD_115200);
    localparam int unsigned DIV_W      = $clog2(DIV_9600 + 1);
    localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W      = $clog2(DATA_BITS);
    localparam int unsigned CNT_W      = $clog2(BUFFER_DEPTH) + 1;

    logic                 rx_meta_q, rx_s_q;
    rx_state_t            state_q, state_d;
    baudrate_t            baud_q, baud_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d, div_last;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 tick, push;
    logic [CNT_W-1:0]     fifo_count;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        div_last = DIV_W'(DIV_115200 - 1);
        case (baud_q)
            BAUD_9600:   div_last = DIV_W'(DIV_9600 - 1);
            BAUD_19200:  div_last = DIV_W'(DIV_19200 - 1);
            BAUD_57600:  div_last = DIV_W'(DIV_57600 - 1);
            default:     div_last = DIV_W'(DIV_115200 - 1);
        endcase
        tick      = (state_q != RX_IDLE) && (div_cnt_q == div_last);
        div_cnt_d = (state_q == RX_IDLE || tick) ? '0 : div_cnt_q + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        tick_cnt_d  = tick ? tick_cnt_q + 1'b1 : tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx_s_q) begin
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    baud_d     = baudrate_t'(baudrate_select_i);
                    state_d    = RX_START;
                end
            end
            RX_START: begin
                if (tick && tick_cnt_q == TICK_W'(OVERSAMPLE / 2 - 1)) begin
                    if (rx_s_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        tick_cnt_d = '0;
                        state_d    = RX_DATA;
                    end
                end
            end
            // Tick count wraps 15->0 on each sample, keeping every later sample mid-bit.
            RX_DATA: begin
                if (tick && tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
                    shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick && tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (rx_s_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
        overrun_d = push && (fifo_count == CNT_W'(BUFFER_DEPTH)) && !data_read_i;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= RX_IDLE;
            baud_q      <= BAUD_9600;
            div_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            div_cnt_q   <= div_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (BUFFER_DEPTH)
    ) u_rx_fifo (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .wr_en_i          (push),
        .wr_data_i        (shift_q),
        .rd_en_i          (data_read_i),
        .thresh_i         (data_buffer_ready_tresh_i),
        .rd_data_o        (data_o),
        .count_o          (fifo_count),
        .empty_o          (data_buffer_empty_o),
        .thresh_reached_o (data_buffer_ready_o)
    );

    assign frame_error_o   = frame_err_q;
    assign overrun_error_o = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 50 MHz with a 4-entry buffer.
module tb_uart_receiver;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned DIV_FAST = 27;   // round(50e6 / (16*115200))
    localparam int unsigned DIV_SLOW = 326;  // round(50e6 / (16*9600))
    localparam int unsigned BIT_FAST = 16 * DIV_FAST;

    // Stop sample lands 2 (sync) + 1 (detect) + 8 + 9*16 ticks - 1 cycles after the pin falls.
    function automatic int unsigned stop_sample(input int unsigned div);
        return 152 * div + 2;
    endfunction

    logic       clock_i = 1'b0;
    logic       reset_i;
    logic       uart_rx_i;
    logic [1:0] baudrate_select_i;
    logic [2:0] data_buffer_ready_tresh_i;
    logic       data_read_i;
    logic [7:0] data_o;
    logic       data_buffer_empty_o;
    logic       data_buffer_ready_o;
    logic       frame_error_o;
    logic       overrun_error_o;

    int unsigned cyc = 0;
    int unsigned fe_cnt = 0;
    int unsigned oe_cnt = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    uart_receiver #(
        .CLOCK_FREQ_HZ (50_000_000),
        .BUFFER_DEPTH  (DEPTH)
    ) dut (
        .clock_i                   (clock_i),
        .reset_i                   (reset_i),
        .uart_rx_i                 (uart_rx_i),
        .baudrate_select_i         (baudrate_select_i),
        .data_buffer_ready_tresh_i (data_buffer_ready_tresh_i),
        .data_read_i               (data_read_i),
        .data_o                    (data_o),
        .data_buffer_empty_o       (data_buffer_empty_o),
        .data_buffer_ready_o       (data_buffer_ready_o),
        .frame_error_o             (frame_error_o),
        .overrun_error_o           (overrun_error_o)
    );

    always #10 clock_i = ~clock_i;

    always @(posedge clock_i) cyc <= cyc + 1;

    always @(negedge clock_i) begin
        if (frame_error_o === 1'b1)   fe_cnt <= fe_cnt + 1;
        if (overrun_error_o === 1'b1) oe_cnt <= oe_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic advance_to(input int unsigned target);
        while (cyc < target) step();
    endtask

    task automatic pop();
        data_read_i = 1'b1;
        step();
        data_read_i = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input int unsigned div,
                              input bit switch_baud, input logic stop_lvl);
        int unsigned bt;
        bt = 16 * div;
        uart_rx_i = 1'b0;
        repeat (bt) step();
        if (switch_baud) baudrate_select_i = 2'b00;
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (bt) step();
        end
        uart_rx_i = stop_lvl;
    endtask

    initial begin
        int unsigned c0;
        logic [7:0] drain_exp [4];

        reset_i                   = 1'b1;
        uart_rx_i                 = 1'b1;
        baudrate_select_i         = 2'b11;
        data_buffer_ready_tresh_i = 3'd1;
        data_read_i               = 1'b0;
        repeat (3) step();
        check_eq("rst_data", data_o, 8'h00);
        check_eq("rst_empty", data_buffer_empty_o, 1'b1);
        check_eq("rst_ready", data_buffer_ready_o, 1'b0);
        check_eq("rst_ferr", frame_error_o, 1'b0);
        check_eq("rst_oerr", overrun_error_o, 1'b0);
        reset_i = 1'b0;
        step();

        // Reset in the middle of a frame must abort it silently.
        uart_rx_i = 1'b0;
        repeat (2 * BIT_FAST) step();
        reset_i = 1'b1;
        repeat (2) step();
        reset_i   = 1'b0;
        uart_rx_i = 1'b1;
        repeat (20) step();
        check_eq("abort_empty", data_buffer_empty_o, 1'b1);
        check_eq("abort_errs", fe_cnt + oe_cnt, 0);

        // 0xA5 at 115200.
        c0 = cyc;
        send_frame(8'hA5, DIV_FAST, 1'b0, 1'b1);
        advance_to(c0 + stop_sample(DIV_FAST));
        check_eq("a5_not_early", data_buffer_empty_o, 1'b1);
        step();
        check_eq("a5_data", data_o, 8'hA5);
        check_eq("a5_empty", data_buffer_empty_o, 1'b0);
        check_eq("a5_ready", data_buffer_ready_o, 1'b1);
        check_eq("a5_ferr", frame_error_o, 1'b0);
        check_eq("a5_oerr", overrun_error_o, 1'b0);
        data_buffer_ready_tresh_i = 3'd0;
        step();
        check_eq("thr0_ready_1", data_buffer_ready_o, 1'b1);
        pop();
        check_eq("a5_pop_empty", data_buffer_empty_o, 1'b1);
        check_eq("a5_pop_data", data_o, 8'h00);
        check_eq("thr0_ready_0", data_buffer_ready_o, 1'b0);
        pop();
        check_eq("pop_on_empty", data_buffer_empty_o, 1'b1);
        data_buffer_ready_tresh_i = 3'd1;

        // Short glitch: START sees the line high again at mid-bit.
        uart_rx_i = 1'b0;
        repeat (3) step();
        uart_rx_i = 1'b1;
        repeat (300) step();
        check_eq("glitch_empty", data_buffer_empty_o, 1'b1);
        check_eq("glitch_errs", fe_cnt + oe_cnt, 0);

        // 0x3C with stop held low for two bit times, then 0x11.
        c0 = cyc;
        send_frame(8'h3C, DIV_FAST, 1'b0, 1'b0);
        advance_to(c0 + stop_sample(DIV_FAST) + 1);
        check_eq("brk_ferr_pulse", frame_error_o, 1'b1);
        check_eq("brk_empty", data_buffer_empty_o, 1'b1);
        step();
        check_eq("brk_ferr_end", frame_error_o, 1'b0);
        advance_to(c0 + 11 * BIT_FAST);
        uart_rx_i = 1'b1;
        repeat (20) step();
        c0 = cyc;
        send_frame(8'h11, DIV_FAST, 1'b0, 1'b1);
        advance_to(c0 + stop_sample(DIV_FAST) + 1);
        check_eq("after_brk_data", data_o, 8'h11);
        check_eq("after_brk_ferr_cnt", fe_cnt, 1);
        pop();
        check_eq("after_brk_empty", data_buffer_empty_o, 1'b1);

        // DEPTH+1 bytes with no reads: last one overruns.
        data_buffer_ready_tresh_i = 3'd4;
        for (int i = 0; i <= DEPTH; i++) begin
            c0 = cyc;
            send_frame(8'(i), DIV_FAST, 1'b0, 1'b1);
            advance_to(c0 + stop_sample(DIV_FAST) + 1);
            check_eq($sformatf("ovr_flag_%0d", i), overrun_error_o, (i == DEPTH) ? 1 : 0);
            check_eq($sformatf("ovr_head_%0d", i), data_o, 8'h00);
            check_eq($sformatf("ovr_ready_%0d", i), data_buffer_ready_o, (i >= DEPTH - 1) ? 1 : 0);
            step();
        end
        check_eq("ovr_pulse_cnt", oe_cnt, 1);

        // Full buffer, pop in the stop-sample cycle; baud select changes mid-frame.
        c0 = cyc;
        send_frame(8'h05, DIV_FAST, 1'b1, 1'b1);
        advance_to(c0 + stop_sample(DIV_FAST));
        check_eq("full_head", data_o, 8'h00);
        pop();
        check_eq("full_no_oerr", overrun_error_o, 1'b0);
        check_eq("full_count_kept", data_buffer_ready_o, 1'b1);
        drain_exp = '{8'h01, 8'h02, 8'h03, 8'h05};
        for (int j = 0; j < 4; j++) begin
            check_eq($sformatf("drain_%0d", j), data_o, drain_exp[j]);
            pop();
        end
        check_eq("drain_empty", data_buffer_empty_o, 1'b1);
        check_eq("drain_data", data_o, 8'h00);
        check_eq("oerr_total", oe_cnt, 1);

        // Next frame latches 9600.
        c0 = cyc;
        send_frame(8'hC3, DIV_SLOW, 1'b0, 1'b1);
        advance_to(c0 + stop_sample(DIV_SLOW));
        check_eq("slow_not_early", data_buffer_empty_o, 1'b1);
        step();
        check_eq("slow_data", data_o, 8'hC3);
        check_eq("slow_empty", data_buffer_empty_o, 1'b0);
        check_eq("ferr_total", fe_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
